// File: rtl/onehot_select_sequencer.sv
// Registered one-hot select generator: loads an index on demand or scans it up/down
// at a programmable rate, with out-of-range load rejection and wrap reporting.
module onehot_select_sequencer #(
  parameter int SEL_W = 3,
  parameter int OUT_N = 8,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [SEL_W-1:0] sel_in,
  input  logic [DIV_W-1:0] div,
  output logic [OUT_N-1:0] y,
  output logic [SEL_W-1:0] idx,
  output logic             valid,
  output logic             err,
  output logic             wrap
);

  typedef enum logic [1:0] {
    MODE_HOLD      = 2'b00,
    MODE_DECODE    = 2'b01,
    MODE_SCAN_UP   = 2'b10,
    MODE_SCAN_DOWN = 2'b11
  } mode_e;

  localparam logic [SEL_W:0]   LIMIT = (SEL_W+1)'(OUT_N);
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(OUT_N - 1);
  localparam logic [OUT_N-1:0] ONE   = OUT_N'(1);

  mode_e            mode_cur, mode_q, mode_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             wrap_q, wrap_d;
  logic [OUT_N-1:0] y_q, y_d;
  logic             tick;

  assign mode_cur = mode_e'(mode);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= MODE_HOLD;
      idx_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      wrap_q  <= 1'b0;
      y_q     <= '0;
    end else begin
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      wrap_q  <= wrap_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    mode_d  = mode_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    wrap_d  = 1'b0;
    tick    = 1'b0;

    if (en) begin
      mode_d = mode_cur;
      // Priority: load beats tick; a mode change suppresses the tick and restarts the count.
      if (mode_cur == MODE_HOLD) begin
        cnt_d = '0;
      end else if (load) begin
        cnt_d = '0;
        if ({1'b0, sel_in} < LIMIT) begin
          idx_d   = sel_in;
          valid_d = 1'b1;
        end else begin
          valid_d = 1'b0;
          err_d   = 1'b1;
        end
      end else if (mode_cur == MODE_DECODE || mode_cur != mode_q) begin
        cnt_d = '0;
      end else if (cnt_q == div) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end

      // Stepping wraps at OUT_N, not at the natural width of idx.
      if (tick) begin
        valid_d = 1'b1;
        if (!valid_q) begin
          idx_d = (mode_cur == MODE_SCAN_UP) ? '0 : LAST;
        end else if (mode_cur == MODE_SCAN_UP) begin
          if (idx_q == LAST) begin
            idx_d  = '0;
            wrap_d = 1'b1;
          end else begin
            idx_d = idx_q + SEL_W'(1);
          end
        end else begin
          if (idx_q == '0) begin
            idx_d  = LAST;
            wrap_d = 1'b1;
          end else begin
            idx_d = idx_q - SEL_W'(1);
          end
        end
      end
    end

    y_d = valid_d ? (ONE << idx_d) : '0;
  end

  assign y     = y_q;
  assign idx   = idx_q;
  assign valid = valid_q;
  assign err   = err_q;
  assign wrap  = wrap_q;

endmodule

// File: doc/onehot_select_sequencer.md
# onehot_select_sequencer

Registered, parametrised successor to the combinational 2:4 decoder. It turns an SEL_W-bit index into an OUT_N-wide one-hot select and can load that index on demand or step it automatically at a programmable rate. It feeds chip-select, row-select and mux-select fabric that needs glitch-free, registered one-hot outputs. It also provides range checking for OUT_N < 2^SEL_W.

## Interface
- SEL_W, default 3, index width; legal range 1..8.
- OUT_N, default 8, number of one-hot outputs; legal range 2..2^SEL_W.
- DIV_W, default 8, width of the step-period divider.

- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  global enable; 0 freezes all state.
- mode  input  2  operating mode: 00 HOLD, 01 DECODE, 10 SCAN_UP, 11 SCAN_DOWN.
- load  input  1  load request for sel_in; honoured in all modes except HOLD.
- sel_in  input  SEL_W  index to load.
- div  input  DIV_W  step period minus one for the scan modes.
- y  output  OUT_N  registered one-hot select, or all-zero when invalid.
- idx  output  SEL_W  registered current index.
- valid  output  1  y holds a legal one-hot value.
- err  output  1  one-cycle pulse when a load is rejected as out of range.
- wrap  output  1  one-cycle pulse when a scan step wraps around.

## Operation
- State: idx register, valid flag, prescaler count (DIV_W bits), and the previous mode (used to detect mode changes).
- y is always derived from registered state: y = valid ? (1 << idx) : 0. y never has more than one bit set.
- When en=0, every register holds its value, and err and wrap are 0.
- HOLD (00):
  - idx and valid hold.
  - load is ignored.
  - Prescaler is cleared.
- Load acceptance (all modes except HOLD, en=1, load=1):
  - sel_in < OUT_N: idx <= sel_in, valid <= 1.
  - sel_in >= OUT_N: valid <= 0, idx holds, err pulses for 1 cycle.
  - Any load clears the prescaler to 0.
- DECODE (01):
  - Only load changes state.
  - Prescaler is held at 0.
- SCAN_UP (10) and SCAN_DOWN (11):
  - Prescaler increments each enabled cycle.
  - When count == div, a tick fires and count returns to 0.
  - Tick with valid=0: idx <= 0 (up) or OUT_N-1 (down), and valid <= 1. No wrap pulse.
  - Tick with valid=1, up: idx <= idx+1, or 0 if idx == OUT_N-1, in which case wrap pulses.
  - Tick with valid=1, down: idx <= idx-1, or OUT_N-1 if idx == 0, in which case wrap pulses.
  - Arithmetic is modulo OUT_N, never modulo 2^SEL_W.
- Priority within one cycle: rst > en=0 > load > tick.
- Any mode change clears the prescaler in that cycle. No tick occurs on the cycle of the change.
- A change to div takes effect on the next comparison. If count > div after the change, the count runs on and wraps at 2^DIV_W before the next tick fires.

## Timing
- Reset values: y=0, idx=0, valid=0, err=0, wrap=0, prescaler=0.
- Asserting rst clears all state immediately, including mid-scan.
- Load latency is 1 cycle: load sampled at edge k gives y, idx, valid (or err) visible after edge k.
- err and wrap are registered. They are high for exactly the one cycle following the causing edge.
- Scan period is div+1 enabled cycles per step. div=0 steps every cycle.
- Time to first tick after a mode change or a load is div+1 enabled cycles, counted from the following edge.
- en=0 cycles stretch the period; they are not counted.
- All outputs are registered, with no combinational path from inputs.

## Test plan
- Reset: assert rst mid-operation, asynchronously between edges -> y=0, idx=0, valid=0, err=0, wrap=0 immediately; no change at the next clk edge while rst is held.
- DECODE, OUT_N=6, SEL_W=3: load 0..7 on consecutive cycles:
  - sel_in 0..5 -> y = 000001 .. 100000 one cycle later, valid=1.
  - sel_in 6 and 7 -> y=0, valid=0, err high one cycle each.
- SCAN_UP, OUT_N=8, div=0, from reset: y steps 0x01, 0x02, ..., 0x80, 0x01 on consecutive cycles; wrap high only in the cycle y returns to 0x01.
- SCAN_DOWN, div=2, after loading idx=1: y=0x02 for 3 cycles, then 0x01 for 3 cycles, then 0x80 with wrap pulse.
- en=0 for 5 cycles mid-scan with div=3: y and prescaler frozen; stepping resumes with the remaining count when en returns to 1.
- Simultaneous events in SCAN_UP with div=0: load sel_in=5 on a tick cycle -> idx=5 (load wins over the tick); next step goes to 6 after 1 cycle. Mode change 10->11 -> no step that cycle; the next step goes downward.
